cga_vram_sched: RTL and testbench

Time-slotted scheduler for the single-port video SRAM shared by the CRTC pixel fetch and the ISA bus. It divides each character period into fixed slots. Pixel fetches always own their slots, so they are never displaced and produce no snow. ISA reads and writes are queued into the remaining slots and stretched with `isa_rdy` (IOCHRDY) until they complete. It sits between the ISA decode / CRTC sequencer and the SRAM pins; tristate gating of `ram_d` is done at top level.

---
 rtl/cga_vram_sched.sv | 216 +++++++++++++++++++++
 tb/tb_cga_vram_sched.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cga_vram_sched.sv
// cga_vram_sched: slotted arbiter for the single-port CGA video SRAM.
// Pixel fetches own fixed slots; ISA cycles fill free slots and stretch IOCHRDY.
module cga_vram_sched #(
    parameter int PERIOD    = 8,
    parameter int PIX_SLOT0 = 0,
    parameter int PIX_SLOT1 = 4,
    parameter int DIN_DELAY = 2
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        char_strobe,
    input  logic        pix_enable,
    input  logic [18:0] pix_addr0,
    input  logic [18:0] pix_addr1,
    output logic [7:0]  pix_char,
    output logic [7:0]  pix_attr,
    output logic        pix_valid,
    input  logic [18:0] isa_addr,
    input  logic [7:0]  isa_din,
    input  logic        isa_read,
    input  logic        isa_write,
    output logic [7:0]  isa_dout,
    output logic        isa_rdy,
    output logic [18:0] ram_a,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    output logic        ram_drive,
    output logic        ram_we_l
);

    localparam int SW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int CW = (DIN_DELAY > 1) ? $clog2(DIN_DELAY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_PEND,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_slot;
    logic [SW-1:0] w_slot_nxt;
    logic [CW-1:0] r_cnt;
    logic [18:0]   r_addr;
    logic [7:0]    r_data;
    logic          r_is_wr;
    logic          r_rd_q;
    logic          r_wr_q;
    logic          r_own_pix0;
    logic          r_own_pix1;
    logic [18:0]   r_ram_a;
    logic [7:0]    r_ram_dout;
    logic          r_ram_drive;
    logic          r_ram_we_l;
    logic [7:0]    r_isa_dout;
    logic          r_isa_rdy;
    logic [7:0]    r_pix_char;
    logic [7:0]    r_pix_attr;
    logic          r_pix_valid;

    logic w_nxt_pix0;
    logic w_nxt_pix1;
    logic w_nxt_free;
    logic w_rd_rise;
    logic w_wr_rise;
    logic w_accept;
    logic w_accept_wr;
    logic w_latch_din;
    logic w_start;
    logic w_rdy_nxt;

    assign w_slot_nxt = (char_strobe || r_slot == SW'(PERIOD - 1))
                        ? '0 : r_slot + 1'b1;

    // Ownership is decided one edge early so ram_a is stable for the slot.
    assign w_nxt_pix0 = pix_enable && (w_slot_nxt == SW'(PIX_SLOT0));
    assign w_nxt_pix1 = pix_enable && (w_slot_nxt == SW'(PIX_SLOT1));
    assign w_nxt_free = !(w_nxt_pix0 || w_nxt_pix1);

    assign w_rd_rise = isa_read && !r_rd_q;
    assign w_wr_rise = isa_write && !r_wr_q;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rd_rise) begin
                    w_state_nxt = S_PEND;
                end else if (w_wr_rise) begin
                    w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                if (r_cnt == CW'(DIN_DELAY - 1)) begin
                    w_state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                if (!r_is_wr && !isa_read) begin
                    w_state_nxt = S_IDLE;
                end else if (w_nxt_free) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: w_state_nxt = S_DONE;
            S_DONE: begin
                if (r_is_wr ? !isa_write : !isa_read) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept    = 1'b0;
        w_accept_wr = 1'b0;
        w_latch_din = 1'b0;
        w_start     = 1'b0;
        w_rdy_nxt   = (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
        if (r_state == S_IDLE) begin
            w_accept    = w_rd_rise || w_wr_rise;
            w_accept_wr = w_wr_rise && !w_rd_rise;
        end
        if (r_state == S_LATCH) begin
            w_latch_din = (r_cnt == CW'(DIN_DELAY - 1));
        end
        if (r_state == S_PEND) begin
            w_start = (w_state_nxt == S_ACCESS);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_slot      <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_is_wr     <= 1'b0;
            r_rd_q      <= isa_read;
            r_wr_q      <= isa_write;
            r_own_pix0  <= 1'b0;
            r_own_pix1  <= 1'b0;
            r_ram_a     <= '0;
            r_ram_dout  <= '0;
            r_ram_drive <= 1'b0;
            r_ram_we_l  <= 1'b1;
            r_isa_dout  <= '0;
            r_isa_rdy   <= 1'b1;
            r_pix_char  <= '0;
            r_pix_attr  <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_slot     <= w_slot_nxt;
            r_rd_q     <= isa_read;
            r_wr_q     <= isa_write;
            r_own_pix0 <= w_nxt_pix0;
            r_own_pix1 <= w_nxt_pix1;
            r_isa_rdy  <= w_rdy_nxt;
            if (w_accept) begin
                r_addr  <= isa_addr;
                r_is_wr <= w_accept_wr;
                r_cnt   <= '0;
            end else if (r_state == S_LATCH) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_latch_din) begin
                r_data <= isa_din;
            end
            if (w_nxt_pix0) begin
                r_ram_a <= pix_addr0;
            end else if (w_nxt_pix1) begin
                r_ram_a <= pix_addr1;
            end else if (w_start) begin
                r_ram_a <= r_addr;
            end
            r_ram_drive <= w_start && r_is_wr;
            r_ram_we_l  <= !(w_start && r_is_wr);
            if (w_start && r_is_wr) begin
                r_ram_dout <= r_data;
            end
            if (r_state == S_ACCESS && !r_is_wr) begin
                r_isa_dout <= ram_din;
            end
            if (r_own_pix0) begin
                r_pix_char <= ram_din;
            end
            if (r_own_pix1) begin
                r_pix_attr <= ram_din;
            end
            r_pix_valid <= r_own_pix1;
        end
    end

    assign pix_char  = r_pix_char;
    assign pix_attr  = r_pix_attr;
    assign pix_valid = r_pix_valid;
    assign isa_dout  = r_isa_dout;
    assign isa_rdy   = r_isa_rdy;
    assign ram_a     = r_ram_a;
    assign ram_dout  = r_ram_dout;
    assign ram_drive = r_ram_drive;
    assign ram_we_l  = r_ram_we_l;

endmodule

// File: tb/tb_cga_vram_sched.sv
// Bench for cga_vram_sched: SRAM model, observed-write queue and
// per-scenario tasks comparing against expectations queued at stimulus time.
module tb_cga_vram_sched;

    typedef struct {
        logic [18:0] a;
        logic [7:0]  d;
        int          slot;
        logic        drv;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        char_strobe;
    logic        pix_enable;
    logic [18:0] pix_addr0;
    logic [18:0] pix_addr1;
    logic [7:0]  pix_char;
    logic [7:0]  pix_attr;
    logic        pix_valid;
    logic [18:0] isa_addr;
    logic [7:0]  isa_din;
    logic        isa_read;
    logic        isa_write;
    logic [7:0]  isa_dout;
    logic        isa_rdy;
    logic [18:0] ram_a;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic        ram_drive;
    logic        ram_we_l;

    logic [7:0] mem [0:524287];
    logic [2:0] tb_slot;
    int         errors = 0;
    int         checks = 0;
    int         pv_count = 0;
    acc_t       obs_q[$];
    acc_t       wr_q[$];
    logic [7:0] rd_q[$];
    logic [15:0] pix_q[$];

    always #5 clk = ~clk;

    cga_vram_sched dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .char_strobe(char_strobe),
        .pix_enable (pix_enable),
        .pix_addr0  (pix_addr0),
        .pix_addr1  (pix_addr1),
        .pix_char   (pix_char),
        .pix_attr   (pix_attr),
        .pix_valid  (pix_valid),
        .isa_addr   (isa_addr),
        .isa_din    (isa_din),
        .isa_read   (isa_read),
        .isa_write  (isa_write),
        .isa_dout   (isa_dout),
        .isa_rdy    (isa_rdy),
        .ram_a      (ram_a),
        .ram_dout   (ram_dout),
        .ram_din    (ram_din),
        .ram_drive  (ram_drive),
        .ram_we_l   (ram_we_l)
    );

    assign ram_din = mem[ram_a];

    always @(posedge clk) begin
        if (ram_we_l === 1'b0) mem[ram_a] <= ram_dout;
        if (!reset_l || char_strobe) tb_slot <= 3'd0;
        else tb_slot <= tb_slot + 3'd1;
    end

    always @(negedge clk) begin
        if (pix_valid === 1'b1) pv_count++;
        if (ram_we_l === 1'b0)
            obs_q.push_back('{a: ram_a, d: ram_dout,
                              slot: int'(tb_slot), drv: ram_drive});
    end

    function automatic int pend_cycles(input int p, input bit pen);
        int n = 1;
        while (pen && (((p + 1) % 8) == 0 || ((p + 1) % 8) == 4)) begin
            p = (p + 1) % 8;
            n++;
        end
        return n;
    endfunction

    task automatic wait_slot(input int s);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(tb_slot) != s && n < 20);
        checks++;
        if (int'(tb_slot) != s) begin
            errors++;
            $display("FAIL wait_slot got=%0d want=%0d", tb_slot, s);
        end
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({isa_rdy, ram_we_l, ram_drive, pix_valid} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_ctl got=%b want=1100",
                     {isa_rdy, ram_we_l, ram_drive, pix_valid});
        end
        checks++;
        if ({ram_a, ram_dout, isa_dout, pix_char, pix_attr} !== '0) begin
            errors++;
            $display("FAIL reset_data a=%h d=%h id=%h c=%h t=%h want 0",
                     ram_a, ram_dout, isa_dout, pix_char, pix_attr);
        end
        reset_l = 1'b1;
    endtask

    task automatic test_pixel();
        int prev = -1;
        int k = 0;
        logic [15:0] e;
        repeat (8) @(negedge clk);
        repeat (3) pix_q.push_back({mem[pix_addr0], mem[pix_addr1]});
        while (pix_q.size() > 0 && k < 40) begin
            @(negedge clk);
            k++;
            if (pix_valid) begin
                e = pix_q.pop_front();
                checks++;
                if ({pix_char, pix_attr} !== e) begin
                    errors++;
                    $display("FAIL pix_bytes got=%h want=%h",
                             {pix_char, pix_attr}, e);
                end
                checks++;
                if (tb_slot != 3'd5) begin
                    errors++;
                    $display("FAIL pix_valid_slot got=%0d want=5", tb_slot);
                end
                if (prev >= 0) begin
                    checks++;
                    if (k - prev != 8) begin
                        errors++;
                        $display("FAIL pix_period got=%0d want=8", k - prev);
                    end
                end
                prev = k;
            end
        end
        checks++;
        if (pix_q.size() != 0) begin
            errors++;
            $display("FAIL pix_timeout left=%0d want=0", pix_q.size());
            pix_q.delete();
        end
    endtask

    task automatic do_read(input logic [18:0] a, input logic [7:0] exp,
                           input int s);
        int p0, n, exp_low, exp_acc, low, last, k;
        logic [7:0] e;
        wait_slot(s);
        isa_addr = a;
        isa_read = 1'b1;
        rd_q.push_back(exp);
        p0 = (s + 1) % 8;
        n = pend_cycles(p0, pix_enable);
        exp_low = n + 1;
        exp_acc = (p0 + n) % 8;
        low = 0;
        last = -1;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (isa_rdy) break;
            low++;
            last = int'(tb_slot);
        end
        e = rd_q.pop_front();
        checks++;
        if (isa_dout !== e || isa_rdy !== 1'b1) begin
            errors++;
            $display("FAIL read_data got=%h rdy=%b want=%h rdy=1",
                     isa_dout, isa_rdy, e);
        end
        checks++;
        if (low != exp_low || last != exp_acc) begin
            errors++;
            $display("FAIL read_timing low=%0d slot=%0d want low=%0d slot=%0d",
                     low, last, exp_low, exp_acc);
        end
        isa_read = 1'b0;
        @(negedge clk);
        checks++;
        if (isa_rdy !== 1'b1 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL read_idle rdy=%b writes=%0d want rdy=1 writes=0",
                     isa_rdy, obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic do_write(input logic [18:0] a, input logic [7:0] d,
                            input int s);
        int p0, n, exp_low, low, k;
        acc_t e, o;
        wait_slot(s);
        isa_addr = a;
        isa_din = 8'h00;
        isa_write = 1'b1;
        p0 = (s + 3) % 8;
        n = pend_cycles(p0, pix_enable);
        exp_low = 2 + n + 1;
        wr_q.push_back('{a: a, d: d, slot: (p0 + n) % 8, drv: 1'b1});
        low = 0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (isa_rdy) break;
            low++;
            if (k == 2) isa_din = d;
            else if (k == 3) isa_din = ~d;
        end
        checks++;
        if (low != exp_low || isa_rdy !== 1'b1) begin
            errors++;
            $display("FAIL write_rdy low=%0d rdy=%b want low=%0d rdy=1",
                     low, isa_rdy, exp_low);
        end
        isa_write = 1'b0;
        @(negedge clk);
        e = wr_q.pop_front();
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL write_count got=%0d want=1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            checks++;
            if (o.a !== e.a || o.d !== e.d || o.drv !== 1'b1
                || o.slot != e.slot) begin
                errors++;
                $display("FAIL write_bus a=%h d=%h drv=%b slot=%0d want a=%h d=%h drv=1 slot=%0d",
                         o.a, o.d, o.drv, o.slot, e.a, e.d, e.slot);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_isa_read();
        do_read(19'h01234, 8'h3C, 7);
        do_read(19'h01234, 8'h3C, 3);
        do_read(19'h01235, 8'hC7, 2);
        checks++;
        if (pix_char !== 8'h41 || pix_attr !== 8'h1F) begin
            errors++;
            $display("FAIL read_pix got=%h/%h want=41/1F", pix_char, pix_attr);
        end
    endtask

    task automatic test_isa_write();
        do_write(19'h0B800, 8'hA5, 1);
        do_read(19'h0B800, 8'hA5, 6);
        do_write(19'h0B801, 8'h3E, 0);
        do_read(19'h0B801, 8'h3E, 5);
    endtask

    task automatic test_blanking();
        int pv0;
        wait_slot(6);
        pix_enable = 1'b0;
        pix_addr0 = 19'h00200;
        pv0 = pv_count;
        do_write(19'h0B802, 8'hC3, 4);
        repeat (16) @(negedge clk);
        checks++;
        if (pv_count != pv0 || pix_char !== 8'h41) begin
            errors++;
            $display("FAIL blank_pix pulses=%0d char=%h want pulses=%0d char=41",
                     pv_count - pv0, pix_char, 0);
        end
        pix_addr0 = 19'h00100;
        wait_slot(6);
        pix_enable = 1'b1;
        do_read(19'h0B802, 8'hC3, 0);
    endtask

    task automatic test_abort();
        int bad = 0;
        wait_slot(2);
        isa_addr = 19'h0ABCD;
        isa_read = 1'b1;
        @(negedge clk);
        checks++;
        if (isa_rdy !== 1'b0) begin
            errors++;
            $display("FAIL abort_wait rdy=%b want=0", isa_rdy);
        end
        isa_read = 1'b0;
        @(negedge clk);
        checks++;
        if (isa_rdy !== 1'b1) begin
            errors++;
            $display("FAIL abort_rdy rdy=%b want=1", isa_rdy);
        end
        repeat (6) begin
            @(negedge clk);
            if (ram_a === 19'h0ABCD || isa_rdy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL abort_access hits=%0d writes=%0d want 0/0",
                     bad, obs_q.size());
            obs_q.delete();
        end
        do_read(19'h01234, 8'h3C, 1);
    endtask

    task automatic test_collision();
        int k = 0;
        wait_slot(7);
        isa_addr = 19'h0C000;
        isa_din = 8'h5A;
        isa_read = 1'b1;
        isa_write = 1'b1;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (isa_rdy) break;
        end
        checks++;
        if (isa_dout !== 8'h33 || k != 3) begin
            errors++;
            $display("FAIL collide_read got=%h cyc=%0d want=33 cyc=3",
                     isa_dout, k);
        end
        isa_read = 1'b0;
        isa_write = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (obs_q.size() != 0 || mem[19'h0C000] !== 8'h33) begin
            errors++;
            $display("FAIL collide_write writes=%0d mem=%h want 0/33",
                     obs_q.size(), mem[19'h0C000]);
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid_write();
        int k = 0;
        wait_slot(3);
        isa_addr = 19'h0B900;
        isa_din = 8'h99;
        isa_write = 1'b1;
        @(negedge clk);
        reset_l = 1'b0;
        isa_write = 1'b0;
        @(negedge clk);
        checks++;
        if ({isa_rdy, ram_we_l, ram_drive, pix_valid} !== 4'b1100) begin
            errors++;
            $display("FAIL midrst_ctl got=%b want=1100",
                     {isa_rdy, ram_we_l, ram_drive, pix_valid});
        end
        reset_l = 1'b1;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (pix_valid) break;
        end
        checks++;
        if (k != 5) begin
            errors++;
            $display("FAIL midrst_slot got=%0d want=5", k);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (obs_q.size() != 0 || mem[19'h0B900] !== 8'h00) begin
            errors++;
            $display("FAIL midrst_write writes=%0d mem=%h want 0/00",
                     obs_q.size(), mem[19'h0B900]);
            obs_q.delete();
        end
    endtask

    task automatic test_char_strobe();
        int k = 0;
        wait_slot(2);
        char_strobe = 1'b1;
        @(negedge clk);
        char_strobe = 1'b0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (pix_valid) break;
        end
        checks++;
        if (k != 5 || pix_char !== 8'h41 || pix_attr !== 8'h1F) begin
            errors++;
            $display("FAIL strobe_resync cyc=%0d c=%h t=%h want 5/41/1F",
                     k, pix_char, pix_attr);
        end
    endtask

    initial begin
        for (int i = 0; i < 524288; i++) mem[i] = 8'h00;
        mem[19'h00100] = 8'h41;
        mem[19'h00101] = 8'h1F;
        mem[19'h00200] = 8'h77;
        mem[19'h01234] = 8'h3C;
        mem[19'h01235] = 8'hC7;
        mem[19'h0C000] = 8'h33;
        reset_l = 1'b0;
        char_strobe = 1'b0;
        pix_enable = 1'b1;
        pix_addr0 = 19'h00100;
        pix_addr1 = 19'h00101;
        isa_addr = '0;
        isa_din = '0;
        isa_read = 1'b0;
        isa_write = 1'b0;
        test_reset();
        test_pixel();
        test_isa_read();
        test_isa_write();
        test_blanking();
        test_abort();
        test_collision();
        test_reset_mid_write();
        test_pixel();
        test_char_strobe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
